// File: rtl/i2c_pkg.sv
// Shared definitions for the WM8731 control-port responder.
//   i2c_state_e    - responder FSM states
//   REG_*          - WM8731 register indices
//   DEV_ADDR_DEFAULT - 7-bit device address with CSB tied low
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_A     = 3'd2,
        ST_BYTE1     = 3'd3,
        ST_ACK1      = 3'd4,
        ST_BYTE2     = 3'd5,
        ST_ACK2      = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    localparam logic [6:0] REG_LLINEIN  = 7'd0;
    localparam logic [6:0] REG_RLINEIN  = 7'd1;
    localparam logic [6:0] REG_LHPOUT   = 7'd2;
    localparam logic [6:0] REG_RHPOUT   = 7'd3;
    localparam logic [6:0] REG_AAPCTL   = 7'd4;
    localparam logic [6:0] REG_DAPCTL   = 7'd5;
    localparam logic [6:0] REG_PWRDN    = 7'd6;
    localparam logic [6:0] REG_DAIF     = 7'd7;
    localparam logic [6:0] REG_SAMPLING = 7'd8;
    localparam logic [6:0] REG_ACTIVE   = 7'd9;
    localparam logic [6:0] REG_RESET    = 7'd15;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one raw I2C line plus a registered edge detector.
//   clk, reset   - system clock, async active-low reset
//   line         - raw line level
//   level        - synchronized level, aligned with rise/fall
//   rise, fall   - one-clk pulses, 3 clk after the line edge
// Flops reset to 1 (idle bus level) so a reset on a quiet bus makes no edges.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line};
            level  <= sync_q[1];
            rise   <= sync_q[1] & ~level;
            fall   <= ~sync_q[1] & level;
        end
    end

endmodule

// File: rtl/i2c_responder.sv
// I2C write-only responder for 3-byte WM8731 frames (address, reg/data MSB, data LSB).
//   clk, reset          - system clock, async active-low reset
//   scl_i, sda_i        - raw bus lines
//   sda_oe              - 1 pulls SDA low (ACK)
//   rd_addr / rd_data   - combinational register-file read port
//   wr_strobe           - one-clk pulse per committed frame
//   wr_addr / wr_data   - register address and 9-bit data of the last commit
//   bus_err             - sticky, START/STOP seen mid-byte
//
// state        | meaning
// ST_IDLE      | waiting for START
// ST_ADDR      | shifting in device address + R/W
// ST_ACK_A     | driving ACK for the address byte
// ST_BYTE1     | shifting in reg address + data bit 8
// ST_ACK1      | driving ACK for byte 1
// ST_BYTE2     | shifting in data bits 7..0
// ST_ACK2      | driving ACK for byte 2 (frame already committed)
// ST_WAIT_STOP | ignoring extra bytes until STOP/START
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         NREG     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       bus_err
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .line  (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .line  (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] byte1_q;
    logic [8:0] reg_file [16];

    logic start_det, stop_det, in_byte, byte_done, addr_match, commit;
    logic [6:0] commit_addr;

    // An SDA edge coinciding with an SCL edge is a data transition, never START/STOP.
    assign start_det  = sda_fall & scl_lvl & ~scl_rise;
    assign stop_det   = sda_rise & scl_lvl & ~scl_rise;
    assign in_byte    = (state_q == ST_ADDR) || (state_q == ST_BYTE1) || (state_q == ST_BYTE2);
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    assign addr_match = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
    assign commit     = (state_q == ST_BYTE2) && (state_d == ST_ACK2);
    assign commit_addr = byte1_q[7:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:  if (byte_done) state_d = addr_match ? ST_ACK_A : ST_IDLE;
                ST_ACK_A: if (scl_fall)  state_d = ST_BYTE1;
                ST_BYTE1: if (byte_done) state_d = ST_ACK1;
                ST_ACK1:  if (scl_fall)  state_d = ST_BYTE2;
                ST_BYTE2: if (byte_done) state_d = ST_ACK2;
                ST_ACK2:  if (scl_fall)  state_d = ST_WAIT_STOP;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bus_err   <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            byte1_q   <= '0;
        end else begin
            // Registered from next state: ACK drive changes 1 clk after the detected SCL fall.
            sda_oe    <= (state_d == ST_ACK_A) || (state_d == ST_ACK1) || (state_d == ST_ACK2);
            wr_strobe <= commit;

            if (start_det || (state_d != state_q)) begin
                bit_cnt <= '0;
            end else if (in_byte && scl_rise && (bit_cnt < 4'd8)) begin
                shift_q <= {shift_q[6:0], sda_lvl};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state_q == ST_BYTE1) && byte_done) byte1_q <= shift_q;

            if (commit) begin
                wr_addr <= commit_addr;
                wr_data <= {byte1_q[0], shift_q};
            end

            if ((start_det || stop_det) && in_byte && (bit_cnt != 4'd0) && (bit_cnt != 4'd8))
                bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) reg_file[i] <= '0;
        end else if (commit) begin
            if (commit_addr == REG_RESET) begin
                for (int i = 0; i < 16; i++) reg_file[i] <= '0;
            end else if (int'(commit_addr) < NREG) begin
                reg_file[commit_addr[3:0]] <= {byte1_q[0], shift_q};
            end
        end
    end

    assign rd_data = reg_file[rd_addr];

endmodule

// File: doc/i2c_responder.md
# i2c_responder

I2C slave that receives the 3-byte WM8731 write frames our codec-configuration master emits: device address, then a 16-bit word of 7-bit register address and 9-bit data. It acknowledges frames for its device address and latches each data word into a 16-entry register file. It is the far end of the codec control link. It runs as a loopback target on the board and as a checked stand-in for the codec in system simulation.

## Interface
Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address that is acknowledged (WM8731, CSB low).
- NREG, 16, number of stored 9-bit registers; register addresses ≥ NREG are acknowledged but not stored.

Ports:
- clk  in  1  system clock (12 MHz PLL output).
- reset  in  1  asynchronous, active-low reset.
- scl_i  in  1  raw SCL line level.
- sda_i  in  1  raw SDA line level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rd_addr  in  4  register-file read index.
- rd_data  out  9  register `rd_addr`, combinational read.
- wr_strobe  out  1  one-clk pulse when a complete frame commits.
- wr_addr  out  7  register address of the last committed frame.
- wr_data  out  9  data of the last committed frame.
- bus_err  out  1  sticky; set on a START or STOP inside a byte (bit count 1–7). Cleared only by reset.

## Operation
- SCL and SDA each pass a 2-FF synchronizer followed by a registered edge detector.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Data bits are sampled on SCL rising edges, MSB first.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP.
- IDLE:
  - START → ADDR, bit count cleared.
  - Everything else is ignored.
- ADDR: after 8 bits, at the SCL falling edge:
  - if addr[7:1] == DEV_ADDR and R/W == 0 → ACK_A, assert sda_oe;
  - otherwise → IDLE with no ACK (NACK).
- ACK_A / ACK1 / ACK2:
  - sda_oe is held through the 9th SCL high phase.
  - sda_oe releases at the next SCL falling edge.
  - The FSM then advances: ACK_A → BYTE1, ACK1 → BYTE2, ACK2 → WAIT_STOP.
- BYTE1 and BYTE2 are always ACKed. At the falling edge after bit 8 of BYTE2:
  - wr_addr = byte1[7:1] and wr_data = {byte1[0], byte2};
  - wr_strobe pulses for one clk;
  - reg[wr_addr] is written if wr_addr < NREG.
- Register address 7'h0F (WM8731 reset) clears every register to 0 instead of storing data; wr_strobe still pulses.
- WAIT_STOP: further bytes are not ACKed and nothing is written.
- Repeated START in any state → ADDR, bit count cleared, sda_oe released.
- STOP in any state → IDLE, sda_oe released.
  - A frame aborted before its commit point writes nothing.
- Reset values:
  - sda_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, bus_err = 0;
  - all registers = 0, state = IDLE.
- Reset may arrive mid-frame. The responder then ignores the bus until the next START.

## Timing
- Line-to-detect latency is 3 clk (2 synchronizer + 1 edge register).
- The master must hold SCL high ≥ 4 clk and low ≥ 4 clk. The existing i2c master meets this by a wide margin.
- sda_oe rises or falls 1 clk after the detected SCL falling edge. This gives ≥ 4 clk of SDA hold after SCL low at the line.
- wr_strobe is asserted 1 clk after the detected falling edge of BYTE2 bit 8. The register file is updated on the same edge.
- rd_data reflects the write from the clk after wr_strobe.
- START/STOP detection needs SCL high to be stable across the SDA edge. An SDA edge on the same clk as an SCL edge is treated as a data transition, not START/STOP.

## Structure
- Shared package `i2c_pkg`:
  - state enum;
  - WM8731 register index constants (LLINEIN 0 … ACTIVE 9, RESET 15);
  - default DEV_ADDR.
- Sub-module `i2c_line_sync`: 2-FF synchronizer plus rise/fall pulse outputs. It is instantiated once for SCL and once for SDA.
- The FSM, shift register, bit counter and register file are in the top.

## Test plan
- Frame 0x34, 0x12, 0x97: ACKs on all three 9th clocks; wr_strobe once with wr_addr = 7'h09 and wr_data = 9'h097; then rd_addr = 9 → rd_data = 9'h097.
- Frame to address 0x36: sda_oe stays 0 throughout, no wr_strobe, FSM in IDLE after the address byte.
- Frame 0x34, 0x08, 0x12 to register 4 = 0x12, then frame 0x34, 0x1E, 0x00 (register 15): all registers read 0, and wr_strobe fires twice in total.
- STOP after BYTE1 (0x34, 0x0E), then a full frame 0x34, 0x0C, 0x1F:
  - the aborted frame writes nothing;
  - register 6 = 9'h01F.
- START after 3 bits of BYTE1: bus_err = 1, FSM in ADDR; a following valid frame commits normally.
- Assert reset while sda_oe = 1 during ACK_A: sda_oe → 0 asynchronously, registers → 0, and no response until the next START.
